// File: rtl/mem_stage_responder_pkg.sv
// Shared types and defaults for the multi-cycle MEM-stage data memory responder.
package mem_stage_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WAIT_CYCLES_DEF = 4;
   localparam int BASE_ADDR_DEF   = 1024;
   localparam int DEPTH_DEF       = 64;

   // Bits needed for a down-counter that starts at n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_stage_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory responder (slave).
interface mem_stage_responder_if;

   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] ST_val;
   logic [31:0] read_data;
   logic        ready;
   logic        err;

   modport master (
      output MEM_R_EN, MEM_W_EN, address, ST_val,
      input  read_data, ready, err
   );

   modport slave (
      input  MEM_R_EN, MEM_W_EN, address, ST_val,
      output read_data, ready, err
   );

endinterface

// File: rtl/mem_stage_responder_data_word_array.sv
// Unreset DEPTH x 32 word storage: synchronous write, combinational read at the same index.
module data_word_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] words [DEPTH];

   always_ff @(posedge clk) begin
      if (we) words[idx] <= wdata;
   end

   assign rdata = words[idx];

endmodule

// File: rtl/mem_stage_responder.sv
// Multi-cycle data memory for the MEM stage: captures one request in IDLE, waits WAIT_CYCLES
// in BUSY, performs the access on the last BUSY edge and reports data/err in DONE.
module mem_stage_responder
   import mem_stage_responder_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int BASE_ADDR   = BASE_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_stage_responder_if.slave  bus
);

   localparam int CW = cnt_width(WAIT_CYCLES);
   localparam int AW = $clog2(DEPTH);

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic           cap_r, cap_w;
   logic [31:0]    cap_addr, cap_val;
   logic [31:0]    rd_q;
   logic           err_q;
   logic           ready_fsm;
   logic           req;
   logic           take;
   logic           acc;
   logic [31:0]    idx32;
   logic           bad;
   logic           we;
   logic [31:0]    rdata;

   assign req  = bus.MEM_R_EN | bus.MEM_W_EN;
   assign take = (state == IDLE) && req;
   assign acc  = (state == BUSY) && (cnt == '0);

   // Unsigned wrap below BASE_ADDR yields a huge index that fails the range test.
   assign idx32 = (cap_addr - 32'(BASE_ADDR)) >> 2;
   assign bad   = (idx32 >= 32'(DEPTH)) || (cap_addr[1:0] != 2'b00);
   assign we    = acc && cap_w && !bad;

   data_word_array #(.DEPTH(DEPTH), .AW(AW)) u_words (
      .clk   (clk),
      .we    (we),
      .idx   (idx32[AW-1:0]),
      .wdata (cap_val),
      .rdata (rdata)
   );

   always_comb begin
      state_nx  = state;
      ready_fsm = 1'b1;
      case (state)
         IDLE: begin
            ready_fsm = ~req;
            if (req) state_nx = BUSY;
         end
         BUSY: begin
            ready_fsm = 1'b0;
            if (cnt == '0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         cap_r <= 1'b0;
         cap_w <= 1'b0;
         rd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            cnt   <= CW'(WAIT_CYCLES - 1);
            cap_r <= bus.MEM_R_EN;
            cap_w <= bus.MEM_W_EN;
         end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         err_q <= acc && (bad || (cap_r && cap_w));
         // Only a pure read touches read_data; writes and combined requests leave it alone.
         if (acc && cap_r && !cap_w) rd_q <= bad ? 32'd0 : rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         cap_addr <= bus.address;
         cap_val  <= bus.ST_val;
      end
   end

   assign bus.ready     = ~rst | ready_fsm;
   assign bus.read_data = rd_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed bench for mem_stage_responder with WAIT_CYCLES=4, DEPTH=64, BASE_ADDR=1024.
module tb_mem_stage_responder;
   import mem_stage_responder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_stage_responder_if bus();

   mem_stage_responder #(.WAIT_CYCLES(4), .DEPTH(64), .BASE_ADDR(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Issue one request at the next edge; count low-ready cycles and sample the DONE cycle.
   task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v,
                         output int lows, output logic [31:0] rd, output logic er);
      @(posedge clk); #1;
      bus.MEM_R_EN = r; bus.MEM_W_EN = w; bus.address = a; bus.ST_val = v;
      lows = 0;
      forever begin
         @(negedge clk);
         if (bus.ready === 1'b1) break;
         lows++;
         if (lows > 40) begin
            lows = -1;
            break;
         end
      end
      rd = bus.read_data;
      er = bus.err;
   endtask

   task automatic drive_idle(input int n);
      @(posedge clk); #1;
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.address = '0; bus.ST_val = '0;
      repeat (n) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL idle: ready=%b err=%b, required ready=1 err=0", bus.ready, bus.err);
         end
      end
   endtask

   task automatic check_req(input string name, input int lows, input logic [31:0] rd, input logic er,
                            input logic [31:0] exp_rd, input logic exp_er);
      checks++;
      if (lows !== 5) begin
         errors++;
         $display("FAIL %s low cycles: got %0d, required 5", name, lows);
      end
      checks++;
      if (rd !== exp_rd) begin
         errors++;
         $display("FAIL %s read_data: got %h, required %h", name, rd, exp_rd);
      end
      checks++;
      if (er !== exp_er) begin
         errors++;
         $display("FAIL %s err: got %b, required %b", name, er, exp_er);
      end
   endtask

   task automatic test_reset();
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.address = '0; bus.ST_val = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b1 || bus.read_data !== 32'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: ready=%b read_data=%h err=%b, required 1/00000000/0",
                     bus.ready, bus.read_data, bus.err);
         end
      end
   endtask

   task automatic test_basic();
      int lows; logic [31:0] rd; logic er;
      do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lows, rd, er);
      check_req("write 1028", lows, rd, er, 32'd0, 1'b0);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, lows, rd, er);
      check_req("read 1028", lows, rd, er, 32'hDEADBEEF, 1'b0);
      drive_idle(2);
   endtask

   task automatic test_back_to_back();
      int lows; logic [31:0] rd; logic er;
      do_req(1'b0, 1'b1, 32'd1024, 32'hA5A50001, lows, rd, er);
      check_req("b2b write 1024", lows, rd, er, 32'hDEADBEEF, 1'b0);
      do_req(1'b0, 1'b1, 32'd1276, 32'h0BADF00D, lows, rd, er);
      check_req("b2b write 1276", lows, rd, er, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, lows, rd, er);
      check_req("b2b read 1024", lows, rd, er, 32'hA5A50001, 1'b0);
      do_req(1'b1, 1'b0, 32'd1276, 32'h0, lows, rd, er);
      check_req("b2b read 1276", lows, rd, er, 32'h0BADF00D, 1'b0);
      drive_idle(1);
   endtask

   task automatic test_errors();
      int lows; logic [31:0] rd; logic er;
      do_req(1'b1, 1'b0, 32'd1280, 32'h0, lows, rd, er);
      check_req("read 1280 out of range", lows, rd, er, 32'd0, 1'b1);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, lows, rd, er);
      check_req("reload 1028", lows, rd, er, 32'hDEADBEEF, 1'b0);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1000, 32'h0, lows, rd, er);
      check_req("read 1000 below base", lows, rd, er, 32'd0, 1'b1);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, lows, rd, er);
      check_req("reload 1024", lows, rd, er, 32'hA5A50001, 1'b0);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1026, 32'h0, lows, rd, er);
      check_req("read 1026 misaligned", lows, rd, er, 32'd0, 1'b1);
      drive_idle(1);
   endtask

   task automatic test_both_enables();
      int lows; logic [31:0] rd; logic er;
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, lows, rd, er);
      check_req("pre-read 1028", lows, rd, er, 32'hDEADBEEF, 1'b0);
      drive_idle(1);
      do_req(1'b1, 1'b1, 32'd1032, 32'h12345678, lows, rd, er);
      check_req("both enables 1032", lows, rd, er, 32'hDEADBEEF, 1'b1);
      drive_idle(1);
      do_req(1'b1, 1'b0, 32'd1032, 32'h0, lows, rd, er);
      check_req("read 1032", lows, rd, er, 32'h12345678, 1'b0);
      drive_idle(1);
   endtask

   task automatic test_reset_abort();
      int lows; logic [31:0] rd; logic er;
      do_req(1'b0, 1'b1, 32'd1036, 32'h11111111, lows, rd, er);
      check_req("write 1036", lows, rd, er, 32'h12345678, 1'b0);
      drive_idle(1);
      @(posedge clk); #1;
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b1; bus.address = 32'd1036; bus.ST_val = 32'hAAAA5555;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL abort ready: got %b, required 1", bus.ready);
      end
      checks++;
      if (dut.state !== IDLE) begin
         errors++;
         $display("FAIL abort state: got %0d, required 0", dut.state);
      end
      checks++;
      if (bus.read_data !== 32'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL abort outputs: read_data=%h err=%b, required 00000000/0", bus.read_data, bus.err);
      end
      @(negedge clk);
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.address = '0; bus.ST_val = '0;
      rst = 1'b1;
      drive_idle(2);
      do_req(1'b1, 1'b0, 32'd1036, 32'h0, lows, rd, er);
      check_req("read 1036 after abort", lows, rd, er, 32'h11111111, 1'b0);
      drive_idle(1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_errors();
      test_both_enables();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
